// File: rtl/uart_packet_handler_pkg.sv
// Shared types and constants for the UART packet handler and its TX sequencer.
package uart_packet_pkg;

    localparam logic [7:0] CMD_WRITE        = 8'h00;
    localparam logic [7:0] CMD_READ         = 8'h01;
    localparam int         STATUS_ERROR_BIT = 7;
    localparam int         RESP_LEN         = 4;

    typedef enum logic [2:0] {
        RX_SYNC, RX_CMD, RX_ADDR, RX_DATA, EXEC, RD_WAIT, RESP
    } pktState_t;

    typedef enum logic [1:0] {
        TX_IDLE, TX_SETUP, TX_HOLD
    } txState_t;

    // Index 0 is the first byte on the wire.
    typedef logic [RESP_LEN-1:0][7:0] respBytes_t;

    // Error status keeps the offending command and flags it.
    function automatic logic [7:0] errStatus(input logic [7:0] cmd);
        logic [7:0] s;
        s = cmd;
        s[STATUS_ERROR_BIT] = 1'b1;
        return s;
    endfunction

endpackage

// File: rtl/uart_packet_handler_if.sv
// UART byte stream plus register bus seen by the packet handler.
interface uart_packet_handler_if;

    logic [7:0] ipRxData;
    logic       ipRxValid;
    logic [7:0] opTxData;
    logic       opTxSend;
    logic       ipTxBusy;
    logic [7:0] opAddress;
    logic [7:0] opWrData;
    logic       opWrEnable;
    logic       opRdEnable;
    logic [7:0] ipRdData;
    logic       ipRdValid;
    logic       opDropped;

    modport master (
        input  ipRxData, ipRxValid, ipTxBusy, ipRdData, ipRdValid,
        output opTxData, opTxSend, opAddress, opWrData, opWrEnable,
               opRdEnable, opDropped
    );

    modport slave (
        output ipRxData, ipRxValid, ipTxBusy, ipRdData, ipRdValid,
        input  opTxData, opTxSend, opAddress, opWrData, opWrEnable,
               opRdEnable, opDropped
    );

endinterface

// File: rtl/uart_packet_handler_tx_sequencer.sv
// Pushes a 4-byte response through the UART transmit handshake.
module uart_tx_sequencer
    import uart_packet_pkg::*;
(
    input  logic       ipClk,
    input  logic       ipReset,
    input  logic       start,
    input  respBytes_t respBytes,
    input  logic       txBusy,
    output logic [7:0] txData,
    output logic       txSend,
    output logic       done
);

    txState_t   state, stateNext;
    logic [1:0] idx, idxNext;
    logic [7:0] txDataNext;
    logic       txSendNext;

    // Register state, byte index and the handshake outputs.
    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            state  <= TX_IDLE;
            idx    <= '0;
            txData <= '0;
            txSend <= 1'b0;
        end else begin
            state  <= stateNext;
            idx    <= idxNext;
            txData <= txDataNext;
            txSend <= txSendNext;
        end
    end

    // Setup waits for an idle transmitter; hold keeps the request until it is taken.
    always_comb begin
        stateNext  = state;
        idxNext    = idx;
        txDataNext = txData;
        txSendNext = txSend;
        done       = 1'b0;
        case (state)
            TX_IDLE: if (start) begin
                idxNext    = '0;
                txDataNext = respBytes[0];
                stateNext  = TX_SETUP;
            end
            TX_SETUP: if (!txBusy) begin
                txSendNext = 1'b1;
                stateNext  = TX_HOLD;
            end
            TX_HOLD: if (txBusy) begin
                txSendNext = 1'b0;
                if (idx == 2'(RESP_LEN - 1)) begin
                    done      = 1'b1;
                    stateNext = TX_IDLE;
                end else begin
                    idxNext    = idx + 2'd1;
                    txDataNext = respBytes[idx + 2'd1];
                    stateNext  = TX_SETUP;
                end
            end
            default: stateNext = TX_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_packet_handler.sv
// Parses SYNC/CMD/ADDR/DATA packets, performs one register access and
// returns a SYNC/STATUS/ADDR/DATA response over the UART.
module uart_packet_handler
    import uart_packet_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE  = 8'h55,
    parameter int         RX_TIMEOUT = 100000,
    parameter int         RD_TIMEOUT = 16
) (
    input  logic                  ipClk,
    input  logic                  ipReset,
    uart_packet_handler_if.master bus
);

    localparam int RXW = $clog2(RX_TIMEOUT + 1);
    localparam int RDW = $clog2(RD_TIMEOUT + 1);

    pktState_t  state, stateNext;
    logic [7:0] cmd, cmdNext;
    logic [7:0] addrNext, wrDataNext;
    logic [7:0] respStatus, statusNext;
    logic [7:0] respData, dataNext;
    logic       wrEnNext, rdEnNext, dropNext;
    logic [RXW-1:0] rxTimer, rxTimerNext;
    logic [RDW-1:0] rdTimer, rdTimerNext;
    logic       inRx, rxExpired, txDone;

    // All parser state and registered bus outputs.
    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            state          <= RX_SYNC;
            cmd            <= '0;
            respStatus     <= '0;
            respData       <= '0;
            rxTimer        <= '0;
            rdTimer        <= '0;
            bus.opAddress  <= '0;
            bus.opWrData   <= '0;
            bus.opWrEnable <= 1'b0;
            bus.opRdEnable <= 1'b0;
            bus.opDropped  <= 1'b0;
        end else begin
            state          <= stateNext;
            cmd            <= cmdNext;
            respStatus     <= statusNext;
            respData       <= dataNext;
            rxTimer        <= rxTimerNext;
            rdTimer        <= rdTimerNext;
            bus.opAddress  <= addrNext;
            bus.opWrData   <= wrDataNext;
            bus.opWrEnable <= wrEnNext;
            bus.opRdEnable <= rdEnNext;
            bus.opDropped  <= dropNext;
        end
    end

    // Next-state: parse, execute, wait for read data, then hand off to TX.
    always_comb begin
        stateNext   = state;
        cmdNext     = cmd;
        addrNext    = bus.opAddress;
        wrDataNext  = bus.opWrData;
        statusNext  = respStatus;
        dataNext    = respData;
        wrEnNext    = 1'b0;
        rdEnNext    = 1'b0;
        dropNext    = 1'b0;
        rxTimerNext = '0;
        rdTimerNext = '0;
        inRx        = (state == RX_CMD) || (state == RX_ADDR) || (state == RX_DATA);
        rxExpired   = inRx && (rxTimer == RXW'(RX_TIMEOUT - 1));
        if (inRx && !bus.ipRxValid && !rxExpired)
            rxTimerNext = rxTimer + 1'b1;
        case (state)
            RX_SYNC: if (bus.ipRxValid) begin
                if (bus.ipRxData == SYNC_BYTE) stateNext = RX_CMD;
                else                           dropNext  = 1'b1;
            end
            RX_CMD, RX_ADDR, RX_DATA: begin
                if (rxExpired) begin
                    // Abandon the partial packet; a coincident byte may start a new one.
                    stateNext = RX_SYNC;
                    if (bus.ipRxValid) begin
                        if (bus.ipRxData == SYNC_BYTE) stateNext = RX_CMD;
                        else                           dropNext  = 1'b1;
                    end
                end else if (bus.ipRxValid) begin
                    if (state == RX_CMD) begin
                        cmdNext   = bus.ipRxData;
                        stateNext = RX_ADDR;
                    end else if (state == RX_ADDR) begin
                        addrNext  = bus.ipRxData;
                        stateNext = RX_DATA;
                    end else begin
                        wrDataNext = bus.ipRxData;
                        wrEnNext   = (cmd == CMD_WRITE);
                        rdEnNext   = (cmd == CMD_READ);
                        stateNext  = EXEC;
                    end
                end
            end
            EXEC: begin
                dropNext = bus.ipRxValid;
                if (cmd == CMD_WRITE) begin
                    statusNext = cmd;
                    dataNext   = bus.opWrData;
                    stateNext  = RESP;
                end else if (cmd == CMD_READ) begin
                    stateNext  = RD_WAIT;
                end else begin
                    statusNext = errStatus(cmd);
                    dataNext   = 8'h00;
                    stateNext  = RESP;
                end
            end
            RD_WAIT: begin
                dropNext = bus.ipRxValid;
                if (bus.ipRdValid) begin
                    statusNext = cmd;
                    dataNext   = bus.ipRdData;
                    stateNext  = RESP;
                end else if (rdTimer == RDW'(RD_TIMEOUT - 1)) begin
                    statusNext = errStatus(cmd);
                    dataNext   = 8'h00;
                    stateNext  = RESP;
                end else begin
                    rdTimerNext = rdTimer + 1'b1;
                end
            end
            RESP: begin
                dropNext = bus.ipRxValid;
                if (txDone) stateNext = RX_SYNC;
            end
            default: stateNext = RX_SYNC;
        endcase
    end

    uart_tx_sequencer uTxSeq (
        .ipClk     (ipClk),
        .ipReset   (ipReset),
        .start     (state == RESP),
        .respBytes ({respData, bus.opAddress, respStatus, SYNC_BYTE}),
        .txBusy    (bus.ipTxBusy),
        .txData    (bus.opTxData),
        .txSend    (bus.opTxSend),
        .done      (txDone)
    );

endmodule

// File: tb/tb_uart_packet_handler.sv
// Directed bench: byte-level UART and register-bus models around the handler.
module tb_uart_packet_handler;

    localparam int RX_TO = 200;

    logic ipClk = 1'b0;
    logic ipReset;
    always #10 ipClk = ~ipClk;

    uart_packet_handler_if busIf ();

    uart_packet_handler #(.SYNC_BYTE(8'h55), .RX_TIMEOUT(RX_TO), .RD_TIMEOUT(16)) dut (
        .ipClk   (ipClk),
        .ipReset (ipReset),
        .bus     (busIf)
    );

    int checkCount = 0;
    int errorCount = 0;

    // Monitor-owned state
    logic [7:0] txLog [0:63];
    int         txCount = 0;
    int         busyCnt = 0;
    int         wrCnt = 0, rdCnt = 0, dropCnt = 0;
    logic [7:0] lastWrAddr = '0, lastWrData = '0;
    // Driven by the main process only
    logic       busyForce = 1'b0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Transmitter model (busy 4 clocks per byte) and strobe counters.
    initial begin
        busIf.ipTxBusy = 1'b0;
        forever begin
            @(negedge ipClk);
            if (busIf.opWrEnable) begin
                wrCnt++;
                lastWrAddr = busIf.opAddress;
                lastWrData = busIf.opWrData;
            end
            if (busIf.opRdEnable) rdCnt++;
            if (busIf.opDropped)  dropCnt++;
            if (busyCnt > 0) busyCnt--;
            else if (busIf.opTxSend && !busIf.ipTxBusy && !busyForce && txCount < 64) begin
                txLog[txCount] = busIf.opTxData;
                txCount++;
                busyCnt = 4;
            end
            busIf.ipTxBusy = busyForce || (busyCnt > 0);
        end
    end

    task automatic sendByte(input logic [7:0] b);
        @(negedge ipClk);
        busIf.ipRxData  = b;
        busIf.ipRxValid = 1'b1;
        @(negedge ipClk);
        busIf.ipRxValid = 1'b0;
    endtask

    // Returns at the negedge just after the DATA byte was sampled.
    task automatic sendPkt(input logic [7:0] b0, b1, b2, b3);
        sendByte(b0); repeat (2) @(negedge ipClk);
        sendByte(b1); repeat (2) @(negedge ipClk);
        sendByte(b2); repeat (2) @(negedge ipClk);
        sendByte(b3);
    endtask

    task automatic checkResp(input string tag, input int base, input logic [31:0] exp);
        int i;
        for (i = 0; i < 3000 && txCount < base + 4; i++) @(negedge ipClk);
        checkVal({tag, "_txdone"}, 32'(txCount >= base + 4), 32'd1);
        if (txCount >= base + 4)
            checkVal({tag, "_bytes"},
                     {txLog[base], txLog[base+1], txLog[base+2], txLog[base+3]}, exp);
        repeat (10) @(negedge ipClk);
        checkVal({tag, "_txcount"}, 32'(txCount - base), 32'd4);
    endtask

    initial begin
        int base, w0, r0, d0, i;
        busIf.ipRxData  = '0;
        busIf.ipRxValid = 1'b0;
        busIf.ipRdData  = '0;
        busIf.ipRdValid = 1'b0;
        ipReset = 1'b1;
        repeat (3) @(negedge ipClk);
        checkVal("rst_txsend", 32'(busIf.opTxSend),   0);
        checkVal("rst_txdata", 32'(busIf.opTxData),   0);
        checkVal("rst_addr",   32'(busIf.opAddress),  0);
        checkVal("rst_wrdata", 32'(busIf.opWrData),   0);
        checkVal("rst_strobe", {29'd0, busIf.opWrEnable, busIf.opRdEnable, busIf.opDropped}, 0);
        ipReset = 1'b0;
        repeat (2) @(negedge ipClk);

        // 1. write
        base = txCount; w0 = wrCnt; r0 = rdCnt;
        sendPkt(8'h55, 8'h00, 8'h12, 8'hA5);
        checkVal("wr_strobe_on", 32'(busIf.opWrEnable), 1);
        checkVal("wr_addr_bus",  32'(busIf.opAddress), 32'h12);
        @(negedge ipClk);
        checkVal("wr_strobe_off", 32'(busIf.opWrEnable), 0);
        checkResp("wr", base, 32'h550012A5);
        checkVal("wr_pulses", 32'(wrCnt - w0), 1);
        checkVal("wr_noread", 32'(rdCnt - r0), 0);
        checkVal("wr_addr",   32'(lastWrAddr), 32'h12);
        checkVal("wr_data",   32'(lastWrData), 32'hA5);

        // 2. read with data 3 clocks later
        base = txCount; w0 = wrCnt; r0 = rdCnt;
        sendPkt(8'h55, 8'h01, 8'h34, 8'h77);
        checkVal("rd_strobe_on", 32'(busIf.opRdEnable), 1);
        repeat (3) @(negedge ipClk);
        busIf.ipRdData  = 8'h5C;
        busIf.ipRdValid = 1'b1;
        @(negedge ipClk);
        busIf.ipRdValid = 1'b0;
        checkResp("rd", base, 32'h5501345C);
        checkVal("rd_pulses", 32'(rdCnt - r0), 1);
        checkVal("rd_nowrite", 32'(wrCnt - w0), 0);

        // 3. read timeout
        base = txCount;
        sendPkt(8'h55, 8'h01, 8'h34, 8'h00);
        repeat (10) @(negedge ipClk);
        checkVal("rdto_early", 32'(txCount - base), 0);
        checkResp("rdto", base, 32'h55813400);

        // 4. unknown command
        base = txCount; w0 = wrCnt; r0 = rdCnt;
        sendPkt(8'h55, 8'h07, 8'h10, 8'hFF);
        checkResp("badcmd", base, 32'h55871000);
        checkVal("badcmd_nostrobe", 32'((wrCnt - w0) + (rdCnt - r0)), 0);

        // 5. junk bytes then a partial packet left to time out
        base = txCount; w0 = wrCnt; r0 = rdCnt; d0 = dropCnt;
        sendByte(8'h00); sendByte(8'hAA); sendByte(8'h55); sendByte(8'h00);
        repeat (RX_TO + 100) @(negedge ipClk);
        checkVal("junk_drops", 32'(dropCnt - d0), 2);
        checkVal("junk_nostrobe", 32'((wrCnt - w0) + (rdCnt - r0)), 0);
        checkVal("junk_notx", 32'(txCount - base), 0);
        sendPkt(8'h55, 8'h00, 8'h20, 8'h3C);
        checkResp("after_to", base, 32'h5500203C);

        // 6. transmitter held busy, byte dropped mid-response, then reset during byte 2
        busyForce = 1'b1;
        @(negedge ipClk);
        base = txCount; d0 = dropCnt;
        sendPkt(8'h55, 8'h00, 8'h40, 8'h11);
        repeat (1000) @(negedge ipClk);
        checkVal("busy_nosend", 32'(busIf.opTxSend), 0);
        checkVal("busy_notx",   32'(txCount - base), 0);
        checkVal("busy_txdata", 32'(busIf.opTxData), 32'h55);
        sendByte(8'h99);
        @(negedge ipClk);
        checkVal("resp_drop", 32'(dropCnt - d0), 1);
        busyForce = 1'b0;
        for (i = 0; i < 3000 && !(txCount >= base + 2 && busIf.opTxSend); i++) @(negedge ipClk);
        checkVal("byte2_send", 32'(busIf.opTxSend), 1);
        ipReset = 1'b1;
        @(negedge ipClk);
        checkVal("rst_abort_send", 32'(busIf.opTxSend), 0);
        @(negedge ipClk);
        ipReset = 1'b0;
        repeat (50) @(negedge ipClk);
        checkVal("rst_abort_count", 32'(txCount - base <= 3), 1);
        base = txCount;
        sendPkt(8'h55, 8'h00, 8'h41, 8'h22);
        checkResp("after_rst", base, 32'h55004122);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
